// File: rtl/addsub_pkg.sv
// Shared constants and flag helper for the pipelined adder/subtractor.
// The overflow helper is also used by the bench reference model.
package addsub_pkg;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Signed overflow: both operands share a sign that the sum does not.
   function automatic logic addsub_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational W-bit ripple-carry slice; one instance per pipeline segment.
module addsub_segment #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign co = c[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: carry chain cut into STAGES ripple segments,
// one beat per cycle, valid/ready on both sides with a global stall.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES >= 1");
   end

   logic              stall;
   logic [STAGES:1]   vld_pipe;
   logic [WIDTH-1:0]  s_q;
   logic              cout_q, ovf_q, zero_q;

   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld_pipe[STAGES];

   // Stage 1 only advances when not stalled, so in_valid here is the accept strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else if (!stall) begin
         vld_pipe[1] <= in_valid;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   // Segment k sees only operand bits not yet consumed (RW wide, LSB-aligned)
   // and the result bits produced by earlier segments.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int RW = WIDTH - k*SEG;

      logic [RW-1:0]         op_a, op_b;
      logic                  ci;
      logic [SEG-1:0]        seg_s;
      logic                  seg_co;
      logic [(k+1)*SEG-1:0]  res;

      if (k == 0) begin : g_src
         assign op_a = a;
         assign op_b = (sub == SUB) ? ~b : b;
         assign ci   = cin;
         assign res  = seg_s;
      end else begin : g_src
         localparam int PW = RW + SEG;

         logic [RW-1:0]      p_a, p_b;
         logic               p_c;
         logic [k*SEG-1:0]   p_s;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               p_a <= '0;
               p_b <= '0;
               p_c <= 1'b0;
               p_s <= '0;
            end else if (!stall) begin
               p_a <= g_st[k-1].op_a[PW-1:SEG];
               p_b <= g_st[k-1].op_b[PW-1:SEG];
               p_c <= g_st[k-1].seg_co;
               p_s <= g_st[k-1].res;
            end
         end

         assign op_a = p_a;
         assign op_b = p_b;
         assign ci   = p_c;
         assign res  = {seg_s, p_s};
      end

      addsub_segment #(.W(SEG)) u_seg (
         .a  (op_a[SEG-1:0]),
         .b  (op_b[SEG-1:0]),
         .ci (ci),
         .s  (seg_s),
         .co (seg_co)
      );
   end

   // Final register: last segment plus flags, all reset to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (!stall) begin
         s_q    <= g_st[LAST].res;
         cout_q <= g_st[LAST].seg_co;
         ovf_q  <= addsub_ovf(g_st[LAST].op_a[SEG-1], g_st[LAST].op_b[SEG-1],
                              g_st[LAST].seg_s[SEG-1]);
         zero_q <= (g_st[LAST].res == '0);
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub at 8/1, 16/4 and 32/8, one configuration
// active at a time; the others sit idle with in_valid held low.
module tb_pipelined_addsub;
   import addsub_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv, ordy, icin, isub;
   logic [31:0] ia, ib;
   int          sel;

   logic        ir0, ov0, c0, o0, z0;
   logic [7:0]  s0;
   logic        ir1, ov1, c1, o1, z1;
   logic [15:0] s1;
   logic        ir2, ov2, c2, o2, z2;
   logic [31:0] s2;

   logic        ir, ov, oc, oo, oz;
   logic [31:0] os;

   int checks   = 0;
   int failures = 0;

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 0), .in_ready(ir0),
      .a(ia[7:0]), .b(ib[7:0]), .cin(icin), .sub(isub),
      .out_valid(ov0), .out_ready(ordy), .s(s0), .cout(c0), .ovf(o0), .zero(z0));

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 1), .in_ready(ir1),
      .a(ia[15:0]), .b(ib[15:0]), .cin(icin), .sub(isub),
      .out_valid(ov1), .out_ready(ordy), .s(s1), .cout(c1), .ovf(o1), .zero(z1));

   pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2), .in_ready(ir2),
      .a(ia), .b(ib), .cin(icin), .sub(isub),
      .out_valid(ov2), .out_ready(ordy), .s(s2), .cout(c2), .ovf(o2), .zero(z2));

   always_comb begin
      ir = ir0; ov = ov0; oc = c0; oo = o0; oz = z0; os = {24'h0, s0};
      if (sel == 1) begin
         ir = ir1; ov = ov1; oc = c1; oo = o1; oz = z1; os = {16'h0, s1};
      end else if (sel == 2) begin
         ir = ir2; ov = ov2; oc = c2; oo = o2; oz = z2; os = s2;
      end
   end

   // Hand-computed 16-bit vectors: a, b, cin, sub -> s, cout, ovf, zero
   logic [15:0] hv_a [6] = '{16'hffff, 16'hfc43, 16'h0005, 16'h0007, 16'h7fff, 16'h8000};
   logic [15:0] hv_b [6] = '{16'h0c45, 16'h0983, 16'h0007, 16'h0007, 16'h0001, 16'h0001};
   logic        hv_c [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        hv_m [6] = '{ADD, ADD, SUB, SUB, ADD, SUB};
   logic [15:0] hx_s [6] = '{16'h0c44, 16'h05c7, 16'hfffe, 16'h0000, 16'h8000, 16'h7fff};
   logic        hx_c [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic        hx_o [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        hx_z [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s sel=%0d got=%h exp=%h", tag, sel, got, exp);
      end
   endtask

   function automatic int width_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 16 : 32;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 8;
   endfunction

   // Reference: {cout, ovf, zero, s} from a plain wide addition.
   function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sb);
      logic [32:0] m, am, bm, sum;
      logic [31:0] r;
      m   = (33'd1 << w) - 33'd1;
      am  = {1'b0, a} & m;
      bm  = {1'b0, (sb ? ~b : b)} & m;
      sum = am + bm + {32'd0, ci};
      r   = sum[31:0] & m[31:0];
      return {sum[w], addsub_ovf(am[w-1], bm[w-1], r[w-1]), (r == 32'd0), r};
   endfunction

   function automatic logic [34:0] obs();
      return {oc, oo, oz, os};
   endfunction

   task automatic xact(input logic [31:0] a, input logic [31:0] b, input logic c, input logic m,
                       output logic [34:0] r, output int lat);
      @(negedge clk);
      ia = a; ib = b; icin = c; isub = m; iv = 1'b1; ordy = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      iv = 1'b0;
      while (!ov && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r = obs();
   endtask

   task automatic run_plan();
      int          w, lmax, lat, sent, got, cyc, extra, first, last, n;
      logic [34:0] r, e;
      logic [31:0] ax, bx;
      logic        acc, drn;
      logic [34:0] exp_q [$];
      w    = width_of(sel);
      lmax = lat_of(sel);

      @(negedge clk);
      iv = 1'b0; ordy = 1'b1; rst_n = 1'b0;
      #1;
      chk("rst_out", obs(), 0);
      chk("rst_ovalid", ov, 0);
      chk("rst_iready", ir, 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         ax = {{16{hv_a[i][15]}}, hv_a[i]};
         bx = {{16{hv_b[i][15]}}, hv_b[i]};
         xact(ax, bx, hv_c[i], hv_m[i], r, lat);
         if (sel == 1) e = {hx_c[i], hx_o[i], hx_z[i], 16'h0, hx_s[i]};
         else          e = model(w, ax, bx, hv_c[i], hv_m[i]);
         chk("vec", r, e);
         chk("latency", lat, lmax);
      end

      // Ten beats against random backpressure.
      sent = 0; got = 0; cyc = 0;
      while (got < 10 && cyc < 400) begin
         @(negedge clk);
         ordy = 1'($urandom_range(0, 1));
         iv   = (sent < 10);
         ia   = 32'h9e37_79b9 * (sent + 1);
         ib   = 32'h7f4a_7c15 ^ (sent * 32'h0101_0101);
         icin = 1'((sent & 1) != 0);
         isub = 1'((sent & 2) != 0);
         #1;
         chk("in_ready", ir, !(ov && !ordy));
         acc = iv && ir;
         drn = ov && ordy;
         if (drn) begin
            if (exp_q.size() == 0) chk("dup_beat", 1, 0);
            else begin
               chk("stream", obs(), exp_q.pop_front());
               got++;
            end
         end
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(model(w, ia, ib, icin, isub));
            sent++;
         end
         cyc++;
      end
      chk("stream_cnt", got, 10);
      iv = 1'b0; ordy = 1'b1; extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (ov) extra++;
      end
      chk("stream_extra", extra, 0);

      // Full throughput with out_ready held high.
      sent = 0; first = -1; last = -1; n = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         iv = (sent < 6); ordy = 1'b1;
         ia = 32'h0000_0100 + c; ib = 32'h0000_0003; icin = 1'b0; isub = 1'b0;
         #1;
         if (ov) begin
            if (first < 0) first = c;
            last = c;
            n++;
         end
         acc = iv && ir;
         @(posedge clk);
         if (acc) sent++;
      end
      iv = 1'b0;
      chk("tput_cnt", n, 6);
      chk("tput_span", last - first, 5);

      // Reset with beats in flight and a result held under backpressure.
      ordy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv = 1'b1; ia = 32'h1234_5678; ib = 32'h0101_0101; icin = 1'b0; isub = 1'b0;
      end
      @(negedge clk);
      iv = 1'b0; n = 0;
      while (!ov && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("held_valid", ov, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("amid_ovalid", ov, 0);
      chk("amid_out", obs(), 0);
      chk("amid_iready", ir, 1);
      @(negedge clk);
      rst_n = 1'b1; ordy = 1'b1; extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (ov) extra++;
      end
      chk("stale_beat", extra, 0);
      ax = 32'hffff_fffb; bx = 32'h0000_0005;
      xact(ax, bx, 1'b1, SUB, r, lat);
      chk("post_rst_vec", r, model(w, ax, bx, 1'b1, SUB));
      chk("post_rst_lat", lat, lmax);
   endtask

   initial begin
      iv = 1'b0; ordy = 1'b1; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0; sel = 0;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         run_plan();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor; the successor to the team's fixed 16-bit ripple adder. The carry chain is cut into `STAGES` equal ripple segments with a register between segments, giving one result per cycle at `STAGES` cycles latency. It adds a runtime add/subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides so it can sit between streaming datapath blocks.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be at least 2.
- `STAGES`, 4: number of pipeline segments; must be at least 1 and must divide `WIDTH` exactly (elaboration error otherwise).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: operand beat present.
- `in_ready`  out  1: block accepts a beat this cycle.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in.
- `sub`  in  1: 0 = add, 1 = subtract.
- `out_valid`  out  1: result beat present.
- `out_ready`  in  1: downstream accepts the result.
- `s`  out  WIDTH: sum or difference.
- `cout`  out  1: carry out of the MSB.
- `ovf`  out  1: signed overflow.
- `zero`  out  1: high when `s` is zero.

## Operation
- Arithmetic for each accepted beat, where B' = `sub` ? ~`b` : `b`:
  - {`cout`,`s`} = `a` + B' + `cin`, computed modulo 2^(WIDTH+1).
  - With `sub`=1, `cin`=1 gives a − b; `cin`=0 gives a − b − 1.
  - In subtract mode, `cout`=0 means a borrow occurred.
- `ovf` = (a[MSB] == B'[MSB]) && (s[MSB] != a[MSB]).
- `zero` = (`s` == 0).
- Datapath structure:
  - Segment k (0 = LSB) adds bits [k·SEG +: SEG], with SEG = WIDTH/STAGES, using the carry registered from segment k−1.
  - Segment 0 uses `cin`.
  - Upper operand bits are carried forward through the stage registers until their segment is reached.
  - Lower result bits are carried forward with the beat.
  - The final register holds `s`, `cout`, `ovf` and `zero`.
- Each stage has a valid bit. Stage 0 captures on the input handshake (`in_valid` && `in_ready`).
- Stall rule:
  - stall = `out_valid` && !`out_ready`.
  - `in_ready` = !stall.
  - While stalled, every stage register, including its valid bit, holds.
  - Otherwise all stages advance by one.
  - Bubbles are not compressed.
- Boundary conditions:
  - `in_valid` low: a bubble (valid=0) enters stage 0.
  - Simultaneous input accept and output drain in the same cycle is the normal full-throughput case; no beat is lost or duplicated.
  - `a`, `b`, `cin` and `sub` are sampled only on the accepting edge. Later changes do not affect beats already in flight.
  - Reset asserted mid-operation clears every valid bit immediately and discards in-flight beats. The first beat after reset release behaves exactly as from a clean start.
- Reset values:
  - `out_valid`=0, `s`=0, `cout`=0, `ovf`=0, `zero`=0.
  - All internal valid bits are 0.
  - `in_ready` = 1 during and after reset, since `out_valid` is 0.

## Timing
- Latency: a beat accepted on edge t is presented with `out_valid`=1 after edge t+STAGES−1+1, i.e. it is visible for the first time following the STAGES-th edge counted from, and including, edge t.
- Throughput: one beat per cycle when `out_ready` is held high.
- Outputs are registered. `in_ready` is the only combinational output and depends on `out_valid` and `out_ready`.
- `STAGES`=1 degenerates to a single registered ripple adder with the same handshake.
- Critical path is one SEG-bit ripple segment plus flag logic in the last stage.

## Structure
- `addsub_pkg`:
  - `ADD` = 1'b0 and `SUB` = 1'b1 mode constants.
  - A function computing signed overflow from (a_msb, b_eff_msb, s_msb), shared with the bench reference model.
- One sub-module, `addsub_segment`:
  - Combinational SEG-bit ripple slice with ports a, b, ci, s, co.
  - Instantiated `STAGES` times via generate.
- Top-level RTL contains the stage registers, valid chain, stall logic and flags.

## Test plan
- WIDTH=16, STAGES=4, add: a=ffff, b=0c45, cin=0 -> s=0c44, cout=1, ovf=0, zero=0, appearing 4 cycles after acceptance.
- Add with carry-in: a=fc43, b=0983, cin=1 -> s=05c7, cout=1, ovf=0.
- Subtract: a=0005, b=0007, sub=1, cin=1 -> s=fffe, cout=0 (borrow), ovf=0. Then a=0007, b=0007, sub=1, cin=1 -> s=0000, cout=1, zero=1.
- Overflow: a=7fff, b=0001, add, cin=0 -> s=8000, ovf=1. Then a=8000, b=0001, sub=1, cin=1 -> s=7fff, ovf=1.
- Backpressure and throughput:
  - Stream 10 back-to-back beats with `out_ready` toggling in a random pattern.
  - Required: `in_ready` is low exactly while `out_valid` && !`out_ready`.
  - Required: all 10 results arrive in order, match the model, with no loss or duplication.
  - Required: with `out_ready` held at 1, one result per cycle.
- Reset mid-stream: assert `rst_n`=0 with 3 beats in flight -> `out_valid` and all outputs drop to 0 asynchronously, and no stale beat emerges after release. Repeat the whole plan at WIDTH=8/STAGES=1 and WIDTH=32/STAGES=8.
